// File: rtl/duty_ramp_ctrl.sv
// Duty ramp controller: slews a PWM duty value toward a requested target
// by STEP once per ramp tick, with a sticky flag for over-range requests.
module duty_ramp_ctrl #(
    parameter int TICK_DIV = 25000,
    parameter int STEP     = 5,
    parameter int MAX_DUTY = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] target,
    input  logic       clr_flag,
    output logic [7:0] duty,
    output logic       busy,
    output logic       at_target,
    output logic       clamp_flag
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0] MAX_D  = 8'(MAX_DUTY);
    localparam logic [8:0] STEP_W = 9'(STEP);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tgt_q, tgt_d;
    logic [7:0]       duty_q, duty_d;
    logic [1:0]       state_q, state_d;
    logic             clamp_q, clamp_d;

    logic             tick;
    logic [7:0]       eff;
    logic [7:0]       eff_d;
    logic [8:0]       up_sum;
    logic [8:0]       dn_diff;

    // Next-state logic: tick timing, target capture, duty slew and direction.
    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);

        // Direction is decided from the live duty/target every cycle, so a
        // new target mid-ramp takes effect without waiting for a tick and the
        // clip against eff keeps duty from ever overshooting it.
        eff     = enable ? tgt_q : 8'd0;
        up_sum  = {1'b0, duty_q} + STEP_W;
        dn_diff = {1'b0, duty_q} - STEP_W;
        duty_d  = duty_q;
        if (tick) begin
            if (duty_q < eff) begin
                duty_d = (up_sum > {1'b0, eff}) ? eff : up_sum[7:0];
            end else if (duty_q > eff) begin
                duty_d = (dn_diff[8] || (dn_diff[7:0] < eff)) ? eff : dn_diff[7:0];
            end
        end

        // A tick in the load cycle still used the old tgt above.
        tgt_d   = load ? ((target > MAX_D) ? MAX_D : target) : tgt_q;
        eff_d   = enable ? tgt_d : 8'd0;

        if (duty_d < eff_d) begin
            state_d = ST_UP;
        end else if (duty_d > eff_d) begin
            state_d = ST_DOWN;
        end else begin
            state_d = ST_IDLE;
        end

        // Setting has priority over clearing when both happen together.
        clamp_d = clamp_q;
        if (clr_flag) begin
            clamp_d = 1'b0;
        end
        if (load && (target > MAX_D)) begin
            clamp_d = 1'b1;
        end
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            tgt_q   <= 8'd0;
            duty_q  <= 8'd0;
            state_q <= ST_IDLE;
            clamp_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            duty_q  <= duty_d;
            state_q <= state_d;
            clamp_q <= clamp_d;
        end
    end

    assign duty       = duty_q;
    assign busy       = (state_q != ST_IDLE);
    assign at_target  = (state_q == ST_IDLE);
    assign clamp_flag = clamp_q;

endmodule
